// File: rtl/wbq_pkg.sv
// wbq_pkg: shared entry type and default sizing for the writeback queue.
package wbq_pkg;
   localparam int DEPTH_DEF  = 4;
   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } wbq_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// writeback_queue_if: result streams in, register-file write port and occupancy out.
interface writeback_queue_if #(
   parameter int DEPTH  = wbq_pkg::DEPTH_DEF,
   parameter int ADDR_W = wbq_pkg::ADDR_W_DEF,
   parameter int DATA_W = wbq_pkg::DATA_W_DEF
);
   logic                         p0_valid;
   logic [ADDR_W-1:0]            p0_addr;
   logic [DATA_W-1:0]            p0_data;
   logic                         p1_valid;
   logic                         p1_ready;
   logic [ADDR_W-1:0]            p1_addr;
   logic [DATA_W-1:0]            p1_data;
   logic [ADDR_W-1:0]            A3;
   logic [DATA_W-1:0]            WD3;
   logic                         RegWriteW;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         empty;
   modport master (
      output p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
      input  p1_ready, A3, WD3, RegWriteW, count, empty
   );
   modport slave (
      input  p0_valid, p0_addr, p0_data, p1_valid, p1_addr, p1_data,
      output p1_ready, A3, WD3, RegWriteW, count, empty
   );
endinterface

// File: rtl/wbq_fifo.sv
// wbq_fifo: 2-write/1-read circular buffer with wrapping pointers and occupancy.
// WBQ_BYPASS_EN exposes storage and head pointer for the lookup search.
module wbq_fifo import wbq_pkg::*; #(
   parameter  int DEPTH = DEPTH_DEF,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH+1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr0_en,
   input  wbq_entry_t      wr0,
   input  logic            wr1_en,
   input  wbq_entry_t      wr1,
   input  logic            rd_en,
   output wbq_entry_t      rd,
   output logic [CW-1:0]   count
`ifdef WBQ_BYPASS_EN
   ,
   output wbq_entry_t [DEPTH-1:0] mem,
   output logic [PW-1:0]          head
`endif
);
   wbq_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d, t1, t2;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      t1 = nxt(tail_q);
      t2 = nxt(t1);
      mem_d = mem_q;
      if (wr0_en) mem_d[tail_q] = wr0;
      // p1 lands behind p0 when both enqueue in the same cycle
      if (wr1_en) mem_d[wr0_en ? t1 : tail_q] = wr1;
      tail_d = (wr0_en && wr1_en) ? t2 : (wr0_en || wr1_en) ? t1 : tail_q;
      head_d = rd_en ? nxt(head_q) : head_q;
      count_d = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign rd    = mem_q[head_q];
   assign count = count_q;
`ifdef WBQ_BYPASS_EN
   assign mem  = mem_q;
   assign head = head_q;
`endif
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: merges pipeline and multi-cycle results into one register-file write per cycle.
// WBQ_BYPASS_EN adds two combinational lookup ports searching pending writes.
module writeback_queue import wbq_pkg::*; #(
   parameter  int DEPTH  = DEPTH_DEF,
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int ADDR_W = ADDR_W_DEF,
   localparam int CW     = $clog2(DEPTH+1)
) (
   input logic                CLOCK,
   input logic                RESET_N,
   writeback_queue_if.slave   bus
`ifdef WBQ_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0]  lk_addr1,
   input  logic [ADDR_W-1:0]  lk_addr2,
   output logic               lk_hit1,
   output logic               lk_hit2,
   output logic [DATA_W-1:0]  lk_data1,
   output logic [DATA_W-1:0]  lk_data2
`endif
);
   wbq_entry_t e0, e1, head_e;
   logic [CW-1:0] count;
   logic enq0, enq1, deq, p1_ready;
   logic [ADDR_W-1:0] a3_q, a3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;
   logic we_q, we_d;
`ifdef WBQ_BYPASS_EN
   localparam int PW = $clog2(DEPTH);
   wbq_entry_t [DEPTH-1:0] mem;
   logic [PW-1:0] head;
`endif

   always_comb begin
      e0 = '{addr: bus.p0_addr, data: bus.p0_data};
      e1 = '{addr: bus.p1_addr, data: bus.p1_data};
      enq0 = bus.p0_valid && (bus.p0_addr != REG_ZERO);
      // holding back p1 at DEPTH-1 keeps a free slot for p0, which cannot stall
      p1_ready = count <= CW'(DEPTH-2);
      enq1 = bus.p1_valid && p1_ready && (bus.p1_addr != REG_ZERO);
      deq = count != '0;
      a3_d  = deq ? head_e.addr : a3_q;
      wd3_d = deq ? head_e.data : wd3_q;
      we_d  = deq;
   end

   wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (CLOCK),
      .rst_n  (RESET_N),
      .wr0_en (enq0),
      .wr0    (e0),
      .wr1_en (enq1),
      .wr1    (e1),
      .rd_en  (deq),
      .rd     (head_e),
      .count  (count)
`ifdef WBQ_BYPASS_EN
      ,
      .mem    (mem),
      .head   (head)
`endif
   );

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         a3_q  <= '0;
         wd3_q <= '0;
         we_q  <= 1'b0;
      end else begin
         a3_q  <= a3_d;
         wd3_q <= wd3_d;
         we_q  <= we_d;
      end
   end

   assign bus.p1_ready  = p1_ready;
   assign bus.A3        = a3_q;
   assign bus.WD3       = wd3_q;
   assign bus.RegWriteW = we_q;
   assign bus.count     = count;
   assign bus.empty     = (count == '0) && !we_q;

`ifdef WBQ_BYPASS_EN
   logic [PW-1:0] idx;
   // oldest first (output register, then head onward) so the youngest match overwrites
   always_comb begin
      idx = '0;
      lk_hit1  = we_q && (a3_q == lk_addr1) && (lk_addr1 != REG_ZERO);
      lk_data1 = wd3_q;
      lk_hit2  = we_q && (a3_q == lk_addr2) && (lk_addr2 != REG_ZERO);
      lk_data2 = wd3_q;
      for (int i = 0; i < DEPTH; i++) begin
         idx = PW'((int'(head) + i) % DEPTH);
         if (CW'(i) < count && mem[idx].addr == lk_addr1 && lk_addr1 != REG_ZERO) begin
            lk_hit1  = 1'b1;
            lk_data1 = mem[idx].data;
         end
         if (CW'(i) < count && mem[idx].addr == lk_addr2 && lk_addr2 != REG_ZERO) begin
            lk_hit2  = 1'b1;
            lk_data2 = mem[idx].data;
         end
      end
   end
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed and randomized checks against a queue-based reference model.
module tb_writeback_queue;
   import wbq_pkg::*;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_queue_if #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) bus();
`ifdef WBQ_BYPASS_EN
   logic [4:0]  lk_addr1 = '0, lk_addr2 = '0;
   logic        lk_hit1, lk_hit2;
   logic [31:0] lk_data1, lk_data2;
`endif

   writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
      .CLOCK   (clk),
      .RESET_N (rst_n),
      .bus     (bus)
`ifdef WBQ_BYPASS_EN
      ,
      .lk_addr1 (lk_addr1),
      .lk_addr2 (lk_addr2),
      .lk_hit1  (lk_hit1),
      .lk_hit2  (lk_hit2),
      .lk_data1 (lk_data1),
      .lk_data2 (lk_data2)
`endif
   );

   typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;
   ent_t        q[$];
   logic [4:0]  ea = '0;
   logic [31:0] ed = '0;
   logic        ewe = 1'b0;
   logic [31:0] rf_m[32];
   logic [31:0] rf_d[32];
   int n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs();
      chk("count", 32'(bus.count), q.size());
      chk("RegWriteW", 32'(bus.RegWriteW), 32'(ewe));
      chk("A3", 32'(bus.A3), 32'(ea));
      chk("WD3", bus.WD3, ed);
      chk("empty", 32'(bus.empty), 32'(q.size() == 0 && !ewe));
      chk("p1_ready", 32'(bus.p1_ready), 32'(q.size() <= DEPTH-2));
   endtask

   function automatic logic [32:0] ref_lk(input logic [4:0] a);
      logic [32:0] r = '0;
      if (ewe && ea == a) r = {1'b1, ed};
      foreach (q[i]) if (q[i].a == a) r = {1'b1, q[i].d};
      if (a == 5'd0) r = '0;
      return r;
   endfunction

   // one cycle: called at a negedge, returns at the next negedge after checking outputs
   task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       output logic acc);
      logic rdy;
      bus.p0_valid = v0; bus.p0_addr = a0; bus.p0_data = d0;
      bus.p1_valid = v1; bus.p1_addr = a1; bus.p1_data = d1;
`ifdef WBQ_BYPASS_EN
      begin
         logic [32:0] r1, r2;
         lk_addr1 = (q.size() > 0) ? q[$urandom_range(0, q.size()-1)].a : 5'($urandom_range(0, 31));
         lk_addr2 = 5'($urandom_range(0, 7));
         #1;
         r1 = ref_lk(lk_addr1);
         r2 = ref_lk(lk_addr2);
         chk("lk_hit1", 32'(lk_hit1), 32'(r1[32]));
         if (r1[32]) chk("lk_data1", lk_data1, r1[31:0]);
         chk("lk_hit2", 32'(lk_hit2), 32'(r2[32]));
         if (r2[32]) chk("lk_data2", lk_data2, r2[31:0]);
      end
`endif
      rdy = q.size() <= DEPTH-2;
      acc = v1 && rdy;
      @(posedge clk);
      if (q.size() > 0) begin
         ea = q[0].a; ed = q[0].d; ewe = 1'b1;
         rf_m[ea] = ed;
         void'(q.pop_front());
      end else ewe = 1'b0;
      if (v0 && a0 != 5'd0) q.push_back('{a: a0, d: d0});
      if (acc && a1 != 5'd0) q.push_back('{a: a1, d: d1});
      @(negedge clk);
      chk_outs();
      if (bus.RegWriteW) rf_d[bus.A3] = bus.WD3;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, acc);
   endtask

   initial begin
      logic acc;
      logic h1v;
      logic [4:0] h1a, a0;
      logic [31:0] h1d;
      foreach (rf_m[i]) begin rf_m[i] = '0; rf_d[i] = '0; end
      bus.p0_valid = 1'b0; bus.p0_addr = '0; bus.p0_data = '0;
      bus.p1_valid = 1'b0; bus.p1_addr = '0; bus.p1_data = '0;
      @(negedge clk);
      chk_outs();
      rst_n = 1'b1;

      // single p0 write: visible after the following edge, gone one edge later
      step(1'b1, 5'd8, 32'h1234, 1'b0, '0, '0, acc);
      chk("lat_pending_we", 32'(bus.RegWriteW), 32'd0);
      idle(1);
      chk("lat_A3", 32'(bus.A3), 32'd8);
      chk("lat_WD3", bus.WD3, 32'h1234);
      chk("lat_we", 32'(bus.RegWriteW), 32'd1);
      idle(1);
      chk("lat_we_drop", 32'(bus.RegWriteW), 32'd0);

      // same register from both ports: p0 lands first, p1 overrides
      step(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, acc);
      chk("r3_acc", 32'(acc), 32'd1);
      idle(1);
      chk("r3_first", bus.WD3, 32'hA);
      idle(1);
      chk("r3_second", bus.WD3, 32'hB);
      idle(1);
      chk("r3_final", rf_d[3], 32'hB);

      // writes to r0 are dropped, p1 still released
      step(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'd5, acc);
      chk("r0_count", 32'(bus.count), 32'd0);
      chk("r0_we", 32'(bus.RegWriteW), 32'd0);
      idle(1);

`ifdef WBQ_BYPASS_EN
      step(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, acc);
      lk_addr1 = 5'd7; lk_addr2 = 5'd0;
      #1;
      chk("byp_hit1", 32'(lk_hit1), 32'd1);
      chk("byp_data1", lk_data1, 32'd2);
      chk("byp_hit2", 32'(lk_hit2), 32'd0);
      idle(3);
`endif

      // saturation: both ports every cycle, p1 holds while stalled
      h1v = 1'b1; h1a = 5'd1; h1d = $urandom;
      for (int i = 0; i < 16; i++) begin
         a0 = 5'($urandom_range(1, 31));
         step(1'b1, a0, $urandom, h1v, h1a, h1d, acc);
         chk("sat_max_occ", 32'(bus.count <= 3'(DEPTH-1)), 32'd1);
         if (acc) begin h1a = 5'($urandom_range(1, 31)); h1d = $urandom; end
      end
      idle(DEPTH + 1);

      // reset with three entries queued
      step(1'b1, 5'd9, 32'h11, 1'b1, 5'd10, 32'h22, acc);
      step(1'b1, 5'd11, 32'h33, 1'b1, 5'd12, 32'h44, acc);
      bus.p0_valid = 1'b0; bus.p1_valid = 1'b0;
      chk("pre_rst_count", 32'(bus.count), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      q.delete(); ewe = 1'b0; ea = '0; ed = '0;
      chk_outs();
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic with small address range for same-register collisions
      h1v = 1'b0; h1a = '0; h1d = '0; acc = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (!h1v || acc) begin
            h1v = 1'($urandom_range(0, 1));
            h1a = 5'($urandom_range(0, 7));
            h1d = $urandom;
         end
         step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
              h1v, h1a, h1d, acc);
      end
      idle(DEPTH + 2);
      for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), rf_d[i], rf_m[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
